fact_mmio_unit: RTL and testbench
=================================

# fact_mmio_unit

Memory-mapped iterative factorial accelerator; four instances sit on the MIPS data bus at bases 0x0003_0000, 0x0004_0000, 0x0005_0000 and 0x0006_0000. Instance i drives `done[i]` of the interrupt controller. The CPU writes an operand N, writes GO, and receives a one-cycle `done` pulse when `N!` is ready. It then reads the result and status.

## Interface
- `BASE_ADDR`, default 32'h0003_0000: instance base. Only bits [31:16] are decoded.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `addr` input 32: bus address. The block is selected when `addr[31:16] == BASE_ADDR[31:16]`. The register offset is `addr[3:2]`.
- `we` input 1: write enable, sampled on `clk` rising edge when the block is selected.
- `wd` input 32: write data.
- `rd` output 32: combinational read data. It is 0 when the block is not selected or the offset is unmapped.
- `done` output 1: registered one-cycle completion pulse to the interrupt controller.

## Operation
- Register map:
  - 0x0 N: read/write; bits [3:0] hold N, the upper bits are ignored on write and read as 0.
  - 0x4 CTRL/STATUS: a write of any value is GO. A read returns {29'b0, err, done_flag, busy}.
  - 0x8 RESULT: read-only.
  - 0xC: unmapped; reads 0, writes ignored.
- States:
  - IDLE: busy=0.
  - CALC: busy=1, acc, cnt.
- GO accepted in IDLE:
  - If N ≤ 12: state←CALC, acc←1, cnt←N, done_flag←0, err←0.
  - If N ≥ 13 (32-bit overflow): no computation. At the next edge: result←0, err←1, done_flag←1, done pulse, state stays IDLE.
- Each CALC edge:
  - If cnt > 1: acc←acc*cnt (low 32 bits of a 32×4 product), cnt←cnt−1.
  - Otherwise: result←acc, done_flag←1, `done` high for exactly one cycle, state←IDLE.
- Writes during CALC:
  - GO while busy is ignored; the running computation is unaffected.
  - A write to N while busy is ignored.
- RESULT holds the previous value until completion. done_flag and err are sticky until the next accepted GO.
- Reset (`rst_n` low at an edge), including mid-computation: state IDLE; N, acc, cnt, result, done_flag, err all 0; `done`=0; no pulse is generated for the aborted computation.

## Timing
- GO is sampled at edge E0.
- For 1 ≤ N ≤ 12, `done` is high during the cycle after edge E(N). For N=0 it is high after E1.
- The error case (N ≥ 13) also pulses after E1.
- busy reads 1 from the cycle after E0 until the cycle `done` is high, in which it reads 0.
- result, done_flag and err update on the same edge that raises `done`.
- A new GO is accepted in the same cycle `done` is high.
- `rd` has zero latency: combinational from `addr` and the current register state.

## Structure
- Package `fact_pkg`:
  - state enum {IDLE, CALC}
  - register offsets OFF_N=2'd0, OFF_CTRL=2'd1, OFF_RESULT=2'd2
  - MAX_N=4'd12
  - status bit indices
- Sub-module `fact_core`: FSM plus acc/cnt datapath. Its ports are start, n[3:0], busy, done, err, result[31:0].
- The top level contains address decode, the N register, status/done_flag and the read mux.

## Test plan
- N=5, GO → `done` pulses one cycle after E5, RESULT=120 (0x78), STATUS=3'b010.
- N=0, then N=1 → each gives RESULT=1 and `done` after E1.
- N=12 → RESULT=0x1C8C_FC00 (479001600), `done` after E12, err=0.
- N=13 → `done` after E1, RESULT=0, STATUS=3'b110. A following N=3 GO clears err and gives RESULT=6.
- N=10 GO, then at E3 write N=2 and a second GO, plus a write to address 0x0004_0008 → all ignored: RESULT=3628800 after E10, a single `done` pulse, `rd`=0 for the off-base address.
- N=8 GO, `rst_n` low at E4 → no `done` pulse, all STATUS/RESULT=0. A GO with N=4 afterwards gives 24.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared types and constants for the memory-mapped factorial accelerator.
package fact_pkg;

    // Core sequencing states: IDLE waits for GO, CALC iterates acc*cnt.
    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } fact_state_t;

    // Word offsets decoded from addr[3:2].
    localparam logic [1:0] OFF_N      = 2'd0;
    localparam logic [1:0] OFF_CTRL   = 2'd1;
    localparam logic [1:0] OFF_RESULT = 2'd2;

    // Largest N whose factorial fits in 32 bits.
    localparam logic [3:0] MAX_N = 4'd12;

    // Bit positions inside the CTRL/STATUS read word.
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: FSM plus acc/cnt datapath, registered result,
// sticky err and a one-cycle done pulse.
//
// Handshake: start is a single-cycle request; it is accepted only when
// busy is low. Once accepted, further start pulses are ignored until the
// cycle in which done is high, where a new start is accepted again.
module fact_core
    import fact_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  n,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result
);

    fact_state_t r_state;
    logic [31:0] r_acc;
    logic [3:0]  r_cnt;
    logic [31:0] r_result;
    logic        r_err;
    logic        r_done;
    // Overflow request seen: complete it (err, result 0) on the next edge.
    logic        r_err_pend;

    // FSM and datapath; all outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_acc      <= 32'd0;
            r_cnt      <= 4'd0;
            r_result   <= 32'd0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_err      <= 1'b0;
                        r_err_pend <= 1'b0;
                        if (n <= MAX_N) begin
                            r_state <= CALC;
                            r_acc   <= 32'd1;
                            r_cnt   <= n;
                        end else begin
                            r_err_pend <= 1'b1;
                        end
                    end else if (r_err_pend) begin
                        r_err_pend <= 1'b0;
                        r_result   <= 32'd0;
                        r_err      <= 1'b1;
                        r_done     <= 1'b1;
                    end
                end
                CALC: begin
                    if (r_cnt > 4'd1) begin
                        r_acc <= r_acc * {28'd0, r_cnt};
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_result <= r_acc;
                        r_done   <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy   = (r_state == CALC);
    assign done   = r_done;
    assign err    = r_err;
    assign result = r_result;

endmodule

// File: rtl/fact_mmio_unit.sv
// Bus-facing wrapper: address decode, N register, done_flag and read mux
// around the factorial core.
module fact_mmio_unit
    import fact_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0003_0000
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        done
);

    logic [3:0]  r_n;
    logic        r_done_flag;

    logic        w_sel;
    logic [1:0]  w_off;
    logic        w_go;
    logic        w_go_acc;
    logic        w_n_wr;
    logic        w_busy;
    logic        w_done;
    logic        w_err;
    logic        w_flag;
    logic [31:0] w_result;
    logic [2:0]  w_status;
    logic        w_unused;

    assign w_sel    = (addr[31:16] == BASE_ADDR[31:16]);
    assign w_off    = addr[3:2];
    assign w_go     = w_sel && we && (w_off == OFF_CTRL);
    assign w_go_acc = w_go && !w_busy;
    assign w_n_wr   = w_sel && we && (w_off == OFF_N) && !w_busy;
    // Address/data bits that carry no meaning for this block.
    assign w_unused = ^{addr[15:4], addr[1:0], wd[31:4]};

    fact_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (w_go),
        .n      (r_n),
        .busy   (w_busy),
        .done   (w_done),
        .err    (w_err),
        .result (w_result)
    );

    // Operand register; frozen while a computation runs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_n <= 4'd0;
        end else if (w_n_wr) begin
            r_n <= wd[3:0];
        end
    end

    // Sticky completion flag, cleared by an accepted GO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done_flag <= 1'b0;
        end else if (w_go_acc) begin
            r_done_flag <= 1'b0;
        end else if (w_done) begin
            r_done_flag <= 1'b1;
        end
    end

    // The pulse cycle itself already reports done_flag=1.
    assign w_flag = r_done_flag | w_done;

    // Status word assembly.
    always_comb begin
        w_status            = 3'd0;
        w_status[STAT_BUSY] = w_busy;
        w_status[STAT_DONE] = w_flag;
        w_status[STAT_ERR]  = w_err;
    end

    // Zero-latency read mux; unselected or unmapped reads return 0.
    always_comb begin
        rd = 32'd0;
        if (w_sel) begin
            case (w_off)
                OFF_N:      rd = {28'd0, r_n};
                OFF_CTRL:   rd = {29'd0, w_status};
                OFF_RESULT: rd = w_result;
                default:    rd = 32'd0;
            endcase
        end
    end

    assign done = w_done;

endmodule

// File: tb/tb_fact_mmio_unit.sv
// Directed bench for fact_mmio_unit: table of factorial vectors plus
// hand-written sequences for busy-time writes, reset abort and back-to-back GO.
module tb_fact_mmio_unit;

    localparam logic [31:0] A_N    = 32'h0003_0000;
    localparam logic [31:0] A_CTRL = 32'h0003_0004;
    localparam logic [31:0] A_RES  = 32'h0003_0008;
    localparam logic [31:0] A_UNM  = 32'h0003_000C;
    localparam int          BUDGET = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        done;

    int n_asrt;
    int n_fail;
    int edge_cnt;
    int done_cnt;

    typedef struct {
        logic [3:0]  n;
        logic [31:0] exp_result;
        int          exp_cycles;
        logic [2:0]  exp_status;
    } vec_t;

    vec_t vecs[10];

    fact_mmio_unit #(.BASE_ADDR(32'h0003_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .we    (we),
        .wd    (wd),
        .rd    (rd),
        .done  (done)
    );

    // Clock and edge/pulse bookkeeping.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_asrt++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        addr = 32'd0;
        wd   = 32'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = rd;
    endtask

    // Waits for done at negedges; returns edges elapsed since e0 (or -1).
    task automatic wait_done(input int e0, output int cycles);
        cycles = -1;
        for (int k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            if (done) begin
                cycles = edge_cnt - e0;
                break;
            end
        end
    endtask

    task automatic run_fact(input string tag, input vec_t v);
        logic [31:0] d;
        int e0, dc0, cyc;
        bus_write(A_N, {28'hABCDEF0, v.n});
        bus_write(A_CTRL, 32'h1);
        e0  = edge_cnt;
        dc0 = done_cnt;
        bus_read(A_CTRL, d);
        check({tag, " busy_after_go"}, {31'd0, d[0]}, (v.n <= 4'd12) ? 32'd1 : 32'd0);
        wait_done(e0, cyc);
        check({tag, " done_latency"}, cyc, v.exp_cycles);
        bus_read(A_CTRL, d);
        check({tag, " status_in_done"}, d, {29'd0, v.exp_status});
        bus_read(A_RES, d);
        check({tag, " result"}, d, v.exp_result);
        @(negedge clk);
        check({tag, " done_width"}, {31'd0, done}, 32'd0);
        check({tag, " done_count"}, done_cnt - dc0, 32'd1);
        bus_read(A_CTRL, d);
        check({tag, " status_sticky"}, d, {29'd0, v.exp_status});
    endtask

    initial begin
        logic [31:0] d;
        int e0, dc0, cyc;

        n_asrt   = 0;
        n_fail   = 0;
        edge_cnt = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        addr     = 32'd0;
        we       = 1'b0;
        wd       = 32'd0;

        vecs[0] = '{4'd5,  32'd120,        5,  3'b010};
        vecs[1] = '{4'd0,  32'd1,          1,  3'b010};
        vecs[2] = '{4'd1,  32'd1,          1,  3'b010};
        vecs[3] = '{4'd12, 32'h1C8C_FC00,  12, 3'b010};
        vecs[4] = '{4'd13, 32'd0,          1,  3'b110};
        vecs[5] = '{4'd3,  32'd6,          3,  3'b010};
        vecs[6] = '{4'd7,  32'd5040,       7,  3'b010};
        vecs[7] = '{4'd15, 32'd0,          1,  3'b110};
        vecs[8] = '{4'd2,  32'd2,          2,  3'b010};
        vecs[9] = '{4'd10, 32'd3628800,    10, 3'b010};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        check("rst done", {31'd0, done}, 32'd0);
        bus_read(A_N, d);    check("rst n", d, 32'd0);
        bus_read(A_CTRL, d); check("rst status", d, 32'd0);
        bus_read(A_RES, d);  check("rst result", d, 32'd0);

        // N register masking, unmapped offset, off-base decode.
        bus_write(A_N, 32'hFFFF_FFF5);
        bus_read(A_N, d);    check("n_mask", d, 32'd5);
        bus_write(A_UNM, 32'h0000_0009);
        bus_read(A_UNM, d);  check("unmapped_read", d, 32'd0);
        bus_read(A_N, d);    check("unmapped_write_ignored", d, 32'd5);
        bus_write(32'h0004_0000, 32'h0000_0007);
        bus_read(A_N, d);    check("offbase_write_ignored", d, 32'd5);
        bus_read(32'h0004_0000, d); check("offbase_read", d, 32'd0);

        // Table of factorial vectors.
        for (int i = 0; i < 10; i++) begin
            run_fact($sformatf("vec%0d_n%0d", i, vecs[i].n), vecs[i]);
        end

        // N=10 with ignored GO/N writes while busy plus an off-base write.
        bus_write(A_N, 32'd10);
        bus_write(A_CTRL, 32'h1);
        e0  = edge_cnt;
        dc0 = done_cnt;
        repeat (2) @(negedge clk);
        bus_write(A_N, 32'd2);
        bus_write(A_CTRL, 32'h1);
        bus_write(32'h0004_0008, 32'hDEAD_BEEF);
        bus_read(32'h0004_0008, d); check("busy offbase_rd", d, 32'd0);
        bus_read(A_N, d);   check("busy n_frozen", d, 32'd10);
        bus_read(A_RES, d); check("busy result_held", d, 32'd3628800);
        bus_read(A_CTRL, d); check("busy status", d, 32'd1);
        wait_done(e0, cyc);
        check("busy done_latency", cyc, 32'd10);
        bus_read(A_RES, d); check("busy result", d, 32'd3628800);
        repeat (15) @(negedge clk);
        check("busy single_pulse", done_cnt - dc0, 32'd1);

        // Reset in the middle of an N=8 computation.
        bus_write(A_N, 32'd8);
        bus_write(A_CTRL, 32'h1);
        dc0 = done_cnt;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("abort no_pulse", done_cnt - dc0, 32'd0);
        bus_read(A_CTRL, d); check("abort status", d, 32'd0);
        bus_read(A_RES, d);  check("abort result", d, 32'd0);
        bus_read(A_N, d);    check("abort n", d, 32'd0);
        run_fact("after_abort_n4", '{4'd4, 32'd24, 4, 3'b010});

        // GO accepted in the very cycle done is high.
        bus_write(A_N, 32'd3);
        bus_write(A_CTRL, 32'h1);
        e0 = edge_cnt;
        wait_done(e0, cyc);
        check("b2b first_latency", cyc, 32'd3);
        addr = A_CTRL;
        wd   = 32'h1;
        we   = 1'b1;
        @(negedge clk);
        we   = 1'b0;
        e0   = edge_cnt;
        bus_read(A_CTRL, d); check("b2b rego_status", d, 32'd1);
        wait_done(e0, cyc);
        check("b2b second_latency", cyc, 32'd3);
        bus_read(A_RES, d);  check("b2b result", d, 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
